// File: rtl/dual_fetch.sv
// rtl/dual_fetch.sv - dual-issue instruction fetch unit with in-order instruction queue
//
// Issues 8-byte-aligned requests to instruction memory (one outstanding at
// most), buffers the returned words with their PCs in a circular queue and
// presents the two oldest entries to decode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               decode stall: queue head is not consumed
//   flush, redirect_pc  redirect: clear queue, restart fetch at redirect_pc
//   imem_req_*          request channel (valid/ready/addr, addr[2:0]=0)
//   imem_resp_*         single-cycle response, data = {word@addr+4, word@addr}
//   pc_0/inst_0/valid_0 oldest queue entry
//   pc_1/inst_1/valid_1 second-oldest queue entry

module dual_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    output logic [31:0] pc_0,
    output logic [31:0] inst_0,
    output logic [31:0] pc_1,
    output logic [31:0] inst_1,
    output logic        valid_0,
    output logic        valid_1
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t state;
    state_t state_next;

    // fetch_pc holds PC bits [31:2]; fetch_pc[0] is PC bit 2 (odd word in the pair)
    logic [29:0] fetch_pc;
    logic [29:0] fetch_pc_next;

    logic [31:0] q_pc   [QDEPTH];
    logic [31:0] q_inst [QDEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;

    logic        req_fire;
    logic        resp_take;
    logic [1:0]  enq_cnt;
    logic [1:0]  deq_cnt;
    logic [31:0] aligned;
    logic [31:0] aligned_p4;

    // Low redirect bits are ignored by design.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign head_p1    = head + PW'(1);
    assign tail_p1    = tail + PW'(1);
    assign free_slots = CW'(QDEPTH) - count;

    assign aligned    = {fetch_pc[29:1], 3'b000};
    assign aligned_p4 = {fetch_pc[29:1], 3'b100};

    assign imem_req_addr  = aligned;
    // Requiring two free slots up front means a response can always be
    // enqueued without checking space; dequeues only ever add room.
    assign imem_req_valid = (state == S_REQ) && (free_slots >= CW'(2)) && !rst;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_take = (state == S_WAIT) && imem_resp_valid && !flush;
    assign enq_cnt   = resp_take ? (fetch_pc[0] ? 2'd1 : 2'd2) : 2'd0;

    assign valid_0 = (count >= CW'(1));
    assign valid_1 = (count >= CW'(2));
    assign deq_cnt = (!stall && !flush) ? ({1'b0, valid_0} + {1'b0, valid_1}) : 2'd0;

    assign pc_0   = q_pc[head];
    assign inst_0 = q_inst[head];
    assign pc_1   = q_pc[head_p1];
    assign inst_1 = q_inst[head_p1];

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    // Next aligned pair; wraps modulo 2^32.
                    fetch_pc_next = {fetch_pc[29:1] + 29'd1, 1'b0};
                    state_next    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase

        // A flush overrides everything; any request still in flight (including
        // one handshaken this cycle) must have its response discarded.
        if (flush) begin
            fetch_pc_next = redirect_pc[31:2];
            case (state)
                S_REQ:   state_next = req_fire ? S_DROP : S_REQ;
                S_WAIT,
                S_DROP:  state_next = imem_resp_valid ? S_REQ : S_DROP;
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC[31:2];
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_cnt);
            tail  <= tail + PW'(enq_cnt);
            count <= count + CW'(enq_cnt) - CW'(deq_cnt);
            if (resp_take) begin
                if (fetch_pc[0]) begin
                    // Fetch started at the odd word: only the upper word is live.
                    q_pc[tail]   <= aligned_p4;
                    q_inst[tail] <= imem_resp_data[63:32];
                end else begin
                    q_pc[tail]      <= aligned;
                    q_inst[tail]    <= imem_resp_data[31:0];
                    q_pc[tail_p1]   <= aligned_p4;
                    q_inst[tail_p1] <= imem_resp_data[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_fetch.sv
// tb/tb_dual_fetch.sv - self-checking bench for dual_fetch with a queue-based reference model

module tb_dual_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          QD  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic [31:0] pc_0;
    logic [31:0] inst_0;
    logic [31:0] pc_1;
    logic [31:0] inst_1;
    logic        valid_0;
    logic        valid_1;

    dual_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .pc_0            (pc_0),
        .inst_0          (inst_0),
        .pc_1            (pc_1),
        .inst_1          (inst_1),
        .valid_0         (valid_0),
        .valid_1         (valid_1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Instruction memory contents: arbitrary but deterministic per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Reference model: queue of {pc, inst}, fetch pc, and request phase
    // (0 = may request, 1 = awaiting response, 2 = response to discard).
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    int          m_mode;

    // Memory model: one pending response with a countdown.
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    int          lat;

    task automatic step(input bit st, input bit fl, input logic [31:0] rp, input bit rdy, input bit rs);
        bit          resp_now;
        bit          e_rv;
        bit          hs_model;
        bit          hs_dut;
        int          deq;
        logic [31:0] al;
        rst            = rs;
        stall          = st;
        flush          = fl;
        redirect_pc    = rp;
        imem_req_ready = rdy;
        resp_now       = pend && (cnt == 0);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? {mem_word(paddr + 32'd4), mem_word(paddr)}
                                   : {$urandom, $urandom};
        #1;
        e_rv = (m_mode == 0) && ((QD - m_q.size()) >= 2) && !rs;
        chk("valid_0", valid_0, m_q.size() >= 1);
        chk("valid_1", valid_1, m_q.size() >= 2);
        if (m_q.size() >= 1) begin
            chk("pc_0", pc_0, m_q[0][63:32]);
            chk("inst_0", inst_0, m_q[0][31:0]);
        end
        if (m_q.size() >= 2) begin
            chk("pc_1", pc_1, m_q[1][63:32]);
            chk("inst_1", inst_1, m_q[1][31:0]);
        end
        chk("req_valid", imem_req_valid, e_rv);
        if (e_rv) chk("req_addr", imem_req_addr, {m_pc[31:3], 3'b000});

        hs_model = e_rv && rdy;
        hs_dut   = imem_req_valid && rdy;

        if (rs) begin
            m_pc   = RPC & ~32'd3;
            m_q.delete();
            m_mode = 0;
        end else if (fl) begin
            if (m_mode == 0) m_mode = hs_model ? 2 : 0;
            else             m_mode = resp_now ? 0 : 2;
            m_q.delete();
            m_pc = rp & ~32'd3;
        end else begin
            deq = st ? 0 : ((m_q.size() >= 2) ? 2 : m_q.size());
            repeat (deq) void'(m_q.pop_front());
            case (m_mode)
                0: if (hs_model) m_mode = 1;
                1: if (resp_now) begin
                    al = m_pc & ~32'd7;
                    if (!m_pc[2]) m_q.push_back({al, mem_word(al)});
                    m_q.push_back({al + 32'd4, mem_word(al + 32'd4)});
                    m_pc   = al + 32'd8;
                    m_mode = 0;
                end
                default: if (resp_now) m_mode = 0;
            endcase
        end

        if (resp_now)  pend = 1'b0;
        else if (pend) cnt--;
        if (hs_dut) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = imem_req_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pend = 1'b0; cnt = 0; paddr = '0; lat = 1;
        m_pc = RPC & ~32'd3; m_mode = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_valid_0", valid_0, 1'b0);
        chk("rst_valid_1", valid_1, 1'b0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_pc_0", pc_0, 32'd0);
        chk("rst_inst_0", inst_0, 32'd0);
        chk("rst_pc_1", pc_1, 32'd0);
        chk("rst_inst_1", inst_1, 32'd0);

        // Streaming from reset, 1-cycle memory: first pair visible in cycle 2
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("first_valid_1", valid_1, 1'b1);
        chk("first_pc_0", pc_0, 32'h0);
        chk("first_pc_1", pc_1, 32'h4);
        repeat (6) step(0, 0, 0, 1, 0);

        // Stall fills the queue and blocks requests
        step(1, 1, 32'h0, 1, 0);
        repeat (12) step(1, 0, 0, 1, 0);
        chk("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_pc_0", pc_0, 32'h0);
        chk("stall_pc_1", pc_1, 32'h4);
        step(0, 0, 0, 1, 0);
        chk("unstall_pc_0", pc_0, 32'h8);
        chk("unstall_pc_1", pc_1, 32'hC);

        // Redirect to an odd word: single entry, then slot 1 filled
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 1, 32'h104, 0, 0);
        chk("redir_addr", imem_req_addr, 32'h100);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("redir_valid_0", valid_0, 1'b1);
        chk("redir_valid_1", valid_1, 1'b0);
        chk("redir_pc_0", pc_0, 32'h104);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("redir_pc_1", pc_1, 32'h108);

        // Stale response while flushing from S_WAIT with latency 3
        lat = 3;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h200, 0, 0);
        repeat (6) step(0, 0, 0, 1, 0);
        lat = 1;

        // Address wrap at the top of memory
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 1, 32'hFFFF_FFF8, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("wrap_pc_0", pc_0, 32'hFFFF_FFF8);
        chk("wrap_pc_1", pc_1, 32'hFFFF_FFFC);
        chk("wrap_req_valid", imem_req_valid, 1'b1);
        chk("wrap_req_addr", imem_req_addr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] rp;
            lat = $urandom_range(1, 3);
            rp  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            if ((n % 700) == 699) begin
                step(0, 0, 0, 0, 1);
                repeat (4) step($urandom_range(0, 1), 0, 0, 0, 0);
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rp,
                     $urandom_range(0, 9) < 7, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
